// File: rtl/head_stepper.sv
// ============================================================================
// Module      : head_stepper
// Description : Snake head stepper. Moves the head one cell every TICK_DIV
//               clocks while running. Reports the committed heading back to
//               the steering control so that it can reject reversals, and
//               detects wall and self collisions.
//               Optional macro SNAKE_WRAP_EN: when defined, the head wraps to
//               the opposite edge instead of dying on a wall.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_dir [1:0]       - requested direction (00 up, 01 down,
//                                   10 left, 11 right), sampled at step edge
//               i_start           - leave IDLE and start running (level)
//               i_self_hit        - head overlaps body (level, used in RUN)
//               i_restart         - leave DEAD and return to IDLE (pulse)
//               o_head_dir [1:0]  - heading committed by the last step
//               o_head_x [XW-1:0] - head column
//               o_head_y [YW-1:0] - head row, row 0 is the top
//               o_step            - pulse in the cycle a new position appears
//               o_running         - high in RUN
//               o_dead            - high in DEAD
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module head_stepper #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int TICK_DIV = 4,
    parameter int START_X  = 8,
    parameter int START_Y  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  i_dir,
    input  logic                        i_start,
    input  logic                        i_self_hit,
    input  logic                        i_restart,
    output logic [1:0]                  o_head_dir,
    output logic [$clog2(GRID_W)-1:0]   o_head_x,
    output logic [$clog2(GRID_H)-1:0]   o_head_y,
    output logic                        o_step,
    output logic                        o_running,
    output logic                        o_dead
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [XW-1:0] C_X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] C_Y_MAX    = YW'(GRID_H - 1);
    localparam logic [XW-1:0] C_X_START  = XW'(START_X);
    localparam logic [YW-1:0] C_Y_START  = YW'(START_Y);
    localparam logic [TW-1:0] C_TICK_MAX = TW'(TICK_DIV - 1);

    localparam logic [1:0] C_DIR_UP    = 2'b00;
    localparam logic [1:0] C_DIR_DOWN  = 2'b01;
    localparam logic [1:0] C_DIR_LEFT  = 2'b10;
    localparam logic [1:0] C_DIR_RIGHT = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [XW-1:0] x_q,       x_d;
    logic [YW-1:0] y_q,       y_d;
    logic [1:0]    dir_q,     dir_d;
    logic [TW-1:0] tick_q,    tick_d;
    logic          step_q,    step_d;
    logic          running_q, running_d;
    logic          dead_q,    dead_d;

    // Candidate next cell for the requested direction, plus wall flag.
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_wall;
    logic          w_tick_end;

    assign w_tick_end = (tick_q == C_TICK_MAX);

    // Bounds are tested on the current unsigned coordinate, so no value ever
    // underflows; the wrap target is an explicit constant, which keeps
    // non-power-of-2 grids correct.
    always_comb begin
        w_nx   = x_q;
        w_ny   = y_q;
        w_wall = 1'b0;
        case (i_dir)
            C_DIR_UP: begin
                if (y_q == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = C_Y_MAX;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_ny = y_q - YW'(1);
                end
            end
            C_DIR_DOWN: begin
                if (y_q == C_Y_MAX) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = '0;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_ny = y_q + YW'(1);
                end
            end
            C_DIR_LEFT: begin
                if (x_q == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = C_X_MAX;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_nx = x_q - XW'(1);
                end
            end
            default: begin
                if (x_q == C_X_MAX) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = '0;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_nx = x_q + XW'(1);
                end
            end
        endcase
    end

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= C_X_START;
            y_q       <= C_Y_START;
            dir_q     <= C_DIR_UP;
            tick_q    <= '0;
            step_q    <= 1'b0;
            running_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            running_q <= running_d;
            dead_q    <= dead_d;
        end
    end

    // Next-state logic. Self hit wins over a step landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_self_hit) begin
                    state_d = ST_DEAD;
                end else if (w_tick_end && w_wall) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (i_restart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic; everything lands in a register.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        dir_d  = dir_q;
        tick_d = tick_q;
        step_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
            end
            ST_RUN: begin
                if (!i_self_hit) begin
                    tick_d = w_tick_end ? '0 : tick_q + TW'(1);
                    if (w_tick_end && !w_wall) begin
                        x_d    = w_nx;
                        y_d    = w_ny;
                        dir_d  = i_dir;
                        step_d = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                // Position frozen so the crash cell stays on screen.
                if (i_restart) begin
                    x_d    = C_X_START;
                    y_d    = C_Y_START;
                    dir_d  = C_DIR_UP;
                    tick_d = '0;
                end
            end
            default: begin
                tick_d = '0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        dead_d    = (state_d == ST_DEAD);
    end

    assign o_head_dir = dir_q;
    assign o_head_x   = x_q;
    assign o_head_y   = y_q;
    assign o_step     = step_q;
    assign o_running  = running_q;
    assign o_dead     = dead_q;

endmodule

`default_nettype wire
